ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the RV32I pipeline. Holds the ID/EX pipeline register and the EX/MEM pipeline register. It consumes the 3-bit ALU control code from the decode stage and applies operand forwarding. It computes the ALU result and resolves branch/jump redirection. Sits between decode (controller + ALU decoder + register file) and the data-memory stage; the hazard unit drives its flush/stall/forward selects.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallE  in  1  hold ID/EX contents
FlushE  in  1  load bubble into ID/EX
RegWriteD  in  1  decode: register write enable
ResultSrcD  in  2  decode: writeback select (00 ALU, 01 mem, 10 PC+4)
MemWriteD  in  1  decode: store enable
JumpD  in  1  decode: jal
BranchD  in  1  decode: beq
ALUSrcD  in  1  decode: 1 = immediate as operand B
ALUControlD  in  3  decode: ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
RD1D, RD2D  in  XLEN  register-file read data
PCD, PCPlus4D, ImmExtD  in  XLEN  PC, PC+4, sign-extended immediate
Rs1D, Rs2D, RdD  in  REGW  register indices
ForwardAE, ForwardBE  in  2  forward select (00 regfile, 01 ResultW, 10 ALUResultM)
ResultW  in  XLEN  writeback-stage result
Rs1E, Rs2E, RdE  out  REGW  EX-stage indices to hazard unit
ResultSrcE0  out  1  EX instruction is a load (for load-use stall)
PCSrcE  out  1  redirect fetch
PCTargetE  out  XLEN  branch/jump target
RegWriteM, MemWriteM  out  1  registered controls to MEM
ResultSrcM  out  2  registered writeback select
ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered data to MEM
RdM  out  REGW  registered destination

Behaviour:
- Reset (rst_n low, asynchronous): every field of both registers clears to 0. All registered outputs read 0. PCSrcE = 0 and PCTargetE = 0 during reset.
- ID/EX register, per rising edge, in priority order:
  - FlushE = 1: all control fields (RegWrite, MemWrite, Jump, Branch, ResultSrc, ALUSrc, ALUControl) and all data/index fields load 0.
  - StallE = 1: all fields hold.
  - Otherwise: all fields load the D-stage inputs.
  - Flush wins over stall when both are asserted.
- Forwarding, combinational:
  - SrcAE = RD1E / ResultW / ALUResultM for ForwardAE 00 / 01 / 10. Code 11 behaves as 00.
  - WriteDataE is RD2E forwarded the same way using ForwardBE.
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, combinational on ALUControlE:
  - 000: A+B; 001: A-B (both modulo 2^XLEN).
  - 010: A&B; 011: A|B.
  - 101: signed A<B gives 1, otherwise 0.
  - Any other code gives 0.
  - ZeroE = (result == 0).
- Branch resolution, combinational:
  - PCTargetE = PCE + ImmExtE, wraps modulo 2^XLEN.
  - PCSrcE = (BranchE & ZeroE) | JumpE.
  - A bubble yields PCSrcE = 0.
- EX/MEM register, per rising edge:
  - StallE = 1: captures a bubble (RegWriteM = 0, MemWriteM = 0, ResultSrcM = 00, data 0), so a held instruction is not issued twice.
  - Otherwise: captures RegWriteE, ResultSrcE, MemWriteE, ALU result, WriteDataE, RdE, PCPlus4E.
- Latency:
  - D inputs captured at edge k are visible on E-stage combinational outputs during cycle k.
  - Those results appear on M outputs after edge k+1.
  - Total: 2 edges from D to M.
- ResultSrcE0 = ResultSrcE[0]. Rs1E, Rs2E and RdE come straight from ID/EX.
- Reset released mid-program: the first post-reset edge loads D inputs normally. No extra bubble is inserted.

Test Plan:
- Reset: hold rst_n=0 with nonzero D inputs, toggle clk -> all M outputs 0, PCSrcE=0. Deassert; next edge loads D normally.
- ALU ops: RD1D=7, RD2D=5, ALUSrcD=0, ALUControlD=000/001/010/011/101 -> ALUResultM = 12 / 2 / 5 / 7 / 0 two edges later. Then RD1D=0xFFFFFFFF (-1), RD2D=1, slt -> 1.
- Forwarding: ForwardAE=10 with previous ALUResultM=0x100, ForwardBE=01 with ResultW=0x20, add -> ALUResultM=0x120, WriteDataM=0x20. ForwardAE=11 -> uses RD1E.
- Branch: BranchD=1, sub, RD1D=RD2D=9, PCD=0x40, ImmExtD=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0x38. Unequal operands -> PCSrcE=0. JumpD=1 -> PCSrcE=1 regardless of ZeroE.
- Flush/stall: FlushE=1 with JumpD=1 -> PCSrcE=0 next cycle. StallE=1 for 2 cycles -> E fields hold and RegWriteM=MemWriteM=0 for those cycles. FlushE=StallE=1 -> bubble loaded.
- Wrap: PCD=0xFFFFFFFC, ImmExtD=8, JumpD=1 -> PCTargetE=0x00000004. Add 0xFFFFFFFF+1 -> ALUResultM=0.

Source files
------------

// File: rtl/ex_stage.sv
// RV32I execute stage: ID/EX register, operand forwarding, ALU, branch/jump
// resolution and the EX/MEM register feeding the data-memory stage.
module ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic            ResultSrcE0,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [REGW-1:0] RdM
);

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [2:0]      alu_control;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] pc_plus4;
    } exmem_t;

    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;

    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] src_b_e;
    logic [XLEN-1:0] alu_result_e;
    logic            zero_e;

    // Flush beats stall so a squashed instruction can never be held in EX.
    always_comb begin
        idex_d = idex_q;
        if (FlushE) begin
            idex_d = '0;
        end else if (!StallE) begin
            idex_d.reg_write   = RegWriteD;
            idex_d.result_src  = ResultSrcD;
            idex_d.mem_write   = MemWriteD;
            idex_d.jump        = JumpD;
            idex_d.branch      = BranchD;
            idex_d.alu_src     = ALUSrcD;
            idex_d.alu_control = ALUControlD;
            idex_d.rd1         = RD1D;
            idex_d.rd2         = RD2D;
            idex_d.pc          = PCD;
            idex_d.pc_plus4    = PCPlus4D;
            idex_d.imm_ext     = ImmExtD;
            idex_d.rs1         = Rs1D;
            idex_d.rs2         = Rs2D;
            idex_d.rd          = RdD;
        end
    end

    always_comb begin
        case (ForwardAE)
            2'b01:   src_a_e = ResultW;
            2'b10:   src_a_e = exmem_q.alu_result;
            default: src_a_e = idex_q.rd1;
        endcase
        case (ForwardBE)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = exmem_q.alu_result;
            default: write_data_e = idex_q.rd2;
        endcase
        src_b_e = idex_q.alu_src ? idex_q.imm_ext : write_data_e;
    end

    always_comb begin
        case (idex_q.alu_control)
            3'b000:  alu_result_e = src_a_e + src_b_e;
            3'b001:  alu_result_e = src_a_e - src_b_e;
            3'b010:  alu_result_e = src_a_e & src_b_e;
            3'b011:  alu_result_e = src_a_e | src_b_e;
            3'b101:  alu_result_e = {{(XLEN-1){1'b0}}, $signed(src_a_e) < $signed(src_b_e)};
            default: alu_result_e = '0;
        endcase
        zero_e = (alu_result_e == '0);
    end

    // While EX is held, MEM receives a bubble so the held instruction issues once.
    always_comb begin
        exmem_d = '0;
        if (!StallE) begin
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.result_src = idex_q.result_src;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.alu_result = alu_result_e;
            exmem_d.write_data = write_data_e;
            exmem_d.rd         = idex_q.rd;
            exmem_d.pc_plus4   = idex_q.pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
        end
    end

    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;
    assign ResultSrcE0 = idex_q.result_src[0];
    assign PCTargetE   = idex_q.pc + idex_q.imm_ext;
    assign PCSrcE      = (idex_q.branch & zero_e) | idex_q.jump;

    assign RegWriteM  = exmem_q.reg_write;
    assign MemWriteM  = exmem_q.mem_write;
    assign ResultSrcM = exmem_q.result_src;
    assign ALUResultM = exmem_q.alu_result;
    assign WriteDataM = exmem_q.write_data;
    assign PCPlus4M   = exmem_q.pc_plus4;
    assign RdM        = exmem_q.rd;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expected values.
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        StallE, FlushE;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ResultSrcE0, PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    int n_vec = 0;
    int n_err = 0;

    ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE0(ResultSrcE0),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] imm, input logic br,
                         input logic jmp, input logic [31:0] pc, input logic [4:0] rd);
        RegWriteD   = 1'b1;
        ResultSrcD  = 2'b00;
        MemWriteD   = 1'b0;
        JumpD       = jmp;
        BranchD     = br;
        ALUSrcD     = src;
        ALUControlD = ctl;
        RD1D        = a;
        RD2D        = b;
        PCD         = pc;
        PCPlus4D    = pc + 32'd4;
        ImmExtD     = imm;
        Rs1D        = 5'd1;
        Rs2D        = 5'd2;
        RdD         = rd;
    endtask

    logic [2:0]  alu_ctl [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b100, 3'b111};
    logic [31:0] alu_exp [7] = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0};

    initial begin
        clk = 1'b0;
        rst_n = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ResultW = 32'h0;
        set_d(3'b000, 32'd7, 32'd5, 1'b0, 32'h10, 1'b0, 1'b1, 32'h100, 5'd3);
        MemWriteD = 1'b1;
        #2 rst_n = 1'b0;

        // Reset with live D inputs.
        repeat (3) tick();
        check("rst_alu_m", ALUResultM, 32'h0);
        check("rst_regwrite_m", {31'b0, RegWriteM}, 32'h0);
        check("rst_memwrite_m", {31'b0, MemWriteM}, 32'h0);
        check("rst_rd_m", {27'b0, RdM}, 32'h0);
        check("rst_pcsrc_e", {31'b0, PCSrcE}, 32'h0);
        check("rst_pctarget_e", PCTargetE, 32'h0);
        check("rst_rd_e", {27'b0, RdE}, 32'h0);

        // First edge after release loads D normally.
        rst_n = 1'b1;
        MemWriteD = 1'b0;
        tick();
        check("post_rst_rd_e", {27'b0, RdE}, 32'd3);
        check("post_rst_pcsrc_e", {31'b0, PCSrcE}, 32'h1);
        check("post_rst_pctarget_e", PCTargetE, 32'h110);
        tick();
        check("post_rst_alu_m", ALUResultM, 32'd12);
        check("post_rst_regwrite_m", {31'b0, RegWriteM}, 32'h1);
        check("post_rst_rd_m", {27'b0, RdM}, 32'd3);
        check("post_rst_pcplus4_m", PCPlus4M, 32'h104);

        // ALU op table on 7,5 including undefined codes.
        for (int i = 0; i < 7; i++) begin
            set_d(alu_ctl[i], 32'd7, 32'd5, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd4);
            tick();
            tick();
            check($sformatf("alu_op_%03b", alu_ctl[i]), ALUResultM, alu_exp[i]);
        end
        set_d(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd4);
        tick();
        tick();
        check("slt_neg", ALUResultM, 32'd1);

        // Branch resolution.
        set_d(3'b001, 32'd9, 32'd9, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h40, 5'd0);
        tick();
        check("beq_taken_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("beq_target", PCTargetE, 32'h38);
        set_d(3'b001, 32'd9, 32'd8, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h40, 5'd0);
        tick();
        check("beq_not_taken", {31'b0, PCSrcE}, 32'h0);
        set_d(3'b001, 32'd9, 32'd8, 1'b0, 32'h20, 1'b0, 1'b1, 32'h40, 5'd1);
        tick();
        check("jal_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("jal_target", PCTargetE, 32'h60);

        // Flush kills a jump.
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        check("flush_pcsrc", {31'b0, PCSrcE}, 32'h0);
        check("flush_rd_e", {27'b0, RdE}, 32'h0);
        check("flush_target", PCTargetE, 32'h0);

        // Stall holds EX and sends bubbles to MEM.
        set_d(3'b000, 32'd1, 32'd2, 1'b0, 32'h0, 1'b0, 1'b0, 32'h200, 5'd7);
        MemWriteD = 1'b1;
        tick();
        check("stall_pre_rd_e", {27'b0, RdE}, 32'd7);
        StallE = 1'b1;
        set_d(3'b000, 32'd100, 32'd100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 5'd9);
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("stall%0d_rd_e", c), {27'b0, RdE}, 32'd7);
            check($sformatf("stall%0d_regwrite_m", c), {31'b0, RegWriteM}, 32'h0);
            check($sformatf("stall%0d_memwrite_m", c), {31'b0, MemWriteM}, 32'h0);
            check($sformatf("stall%0d_alu_m", c), ALUResultM, 32'h0);
        end
        StallE = 1'b0;
        tick();
        check("unstall_alu_m", ALUResultM, 32'd3);
        check("unstall_memwrite_m", {31'b0, MemWriteM}, 32'h1);
        check("unstall_rd_m", {27'b0, RdM}, 32'd7);
        check("unstall_rd_e", {27'b0, RdE}, 32'd9);

        // Flush and stall together load a bubble.
        set_d(3'b000, 32'd1, 32'd1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 5'd11);
        FlushE = 1'b1;
        StallE = 1'b1;
        tick();
        FlushE = 1'b0;
        StallE = 1'b0;
        check("flushstall_rd_e", {27'b0, RdE}, 32'h0);
        check("flushstall_pcsrc", {31'b0, PCSrcE}, 32'h0);
        check("flushstall_regwrite_m", {31'b0, RegWriteM}, 32'h0);

        // Load-type writeback select.
        set_d(3'b000, 32'h30, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 5'd5);
        ResultSrcD = 2'b01;
        tick();
        check("load_resultsrc_e0", {31'b0, ResultSrcE0}, 32'h1);
        tick();
        check("load_resultsrc_m", {30'b0, ResultSrcM}, 32'h1);
        check("load_alu_m", ALUResultM, 32'h34);
        check("load_pcplus4_m", PCPlus4M, 32'h304);

        // Wrap-around cases.
        set_d(3'b000, 32'h0, 32'h0, 1'b0, 32'd8, 1'b0, 1'b1, 32'hFFFF_FFFC, 5'd1);
        tick();
        check("wrap_target", PCTargetE, 32'h4);
        check("wrap_pcsrc", {31'b0, PCSrcE}, 32'h1);
        set_d(3'b000, 32'hFFFF_FFFF, 32'h99, 1'b1, 32'd1, 1'b0, 1'b0, 32'h0, 5'd2);
        tick();
        tick();
        check("wrap_add_imm", ALUResultM, 32'h0);
        check("wrap_writedata_m", WriteDataM, 32'h99);

        // Forwarding from MEM (A) and WB (B).
        set_d(3'b000, 32'h80, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd6);
        tick();
        tick();
        check("fwd_seed_alu_m", ALUResultM, 32'h100);
        set_d(3'b000, 32'h5555, 32'h7777, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd6);
        tick();
        ForwardAE = 2'b10;
        ForwardBE = 2'b01;
        ResultW = 32'h20;
        tick();
        check("fwd_alu_m", ALUResultM, 32'h120);
        check("fwd_writedata_m", WriteDataM, 32'h20);

        // Select 11 falls back to register-file data.
        set_d(3'b000, 32'h10, 32'h3, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd6);
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        tick();
        ForwardAE = 2'b11;
        ForwardBE = 2'b11;
        tick();
        check("fwd11_alu_m", ALUResultM, 32'h13);
        check("fwd11_writedata_m", WriteDataM, 32'h3);
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
